// File: rtl/dispatch_buffer_pkg.sv
// Shared definitions for the dispatch buffer: machine width, buffer depth
// and the decoded-instruction packet handed from decode to rename/ROB.
package dispatch_buffer_pkg;

    localparam int SYS_N_WAY  = 2;
    localparam int DBUF_DEPTH = 8;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        halt;
        logic        illegal;
    } DISPATCH_PACKET;

endpackage

// File: rtl/prefix_count.sv
// Counts the leading ones of a vector, starting at bit 0.
module prefix_count #(
    parameter int W = 2
) (
    input  logic [W-1:0]       vec,
    output logic [$clog2(W):0] cnt
);

    logic run;

    // Stop counting at the first zero so only the contiguous prefix is seen
    always_comb begin
        cnt = '0;
        run = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (run && vec[i]) cnt = cnt + 1'b1;
            else               run = 1'b0;
        end
    end

endmodule

// File: rtl/dispatch_buffer.sv
// In-order queue between decode and the rename/ROB cluster. Accepts up to
// N_WAY packets per cycle, presents the oldest N_WAY, retires the prefix of
// slots the cluster took, flushes on branch_haz and locks after halt/illegal.
module dispatch_buffer
    import dispatch_buffer_pkg::*;
#(
    parameter  int N_WAY = SYS_N_WAY,
    parameter  int DEPTH = DBUF_DEPTH,
    localparam int CW    = $clog2(N_WAY) + 1,
    localparam int PW    = $clog2(DEPTH),
    localparam int OW    = PW + 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  DISPATCH_PACKET [N_WAY-1:0]  in_packet,
    input  logic [CW-1:0]               in_num,
    output logic [CW-1:0]               in_accept,
    output DISPATCH_PACKET [N_WAY-1:0]  dispatch_packet,
    output logic [CW-1:0]               dispatch_num,
    input  logic [N_WAY-1:0]            dispatched,
    input  logic                        branch_haz,
    output logic                        halted,
    output logic [OW-1:0]               count
);

    DISPATCH_PACKET      mem [DEPTH];
    logic [PW-1:0]       head, tail;
    logic [N_WAY-1:0]    dmask, ok_mask;
    logic [CW-1:0]       deq, lead_ok, lim;
    logic [OW-1:0]       free;
    logic                halt_take;

    prefix_count #(.W(N_WAY)) u_deq  (.vec(dmask),   .cnt(deq));
    prefix_count #(.W(N_WAY)) u_halt (.vec(ok_mask), .cnt(lead_ok));

    // Present the oldest entries; slots past occupancy read as zero
    always_comb begin
        dispatch_num = (count > OW'(N_WAY)) ? CW'(N_WAY) : count[CW-1:0];
        for (int i = 0; i < N_WAY; i++) begin
            dispatch_packet[i] = '0;
            if (CW'(i) < dispatch_num)
                dispatch_packet[i] = mem[PW'(head + PW'(i))];
            dmask[i] = dispatched[i] & dispatch_packet[i].valid;
        end
    end

    // Acceptance uses registered occupancy only, so the ROB's dispatched
    // mask never feeds back into in_accept within a cycle
    always_comb begin
        free = OW'(DEPTH) - count;
        lim  = (in_num > CW'(N_WAY)) ? CW'(N_WAY) : in_num;
        if (OW'(lim) > free) lim = free[CW-1:0];
        for (int k = 0; k < N_WAY; k++)
            ok_mask[k] = ~(in_packet[k].halt | in_packet[k].illegal);
        in_accept = lim;
        halt_take = 1'b0;
        if (lead_ok < lim) begin
            in_accept = lead_ok + 1'b1;
            halt_take = 1'b1;
        end
        if (halted || branch_haz) begin
            in_accept = '0;
            halt_take = 1'b0;
        end
    end

    // Pointers, occupancy, halt lock and entry storage
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            halted <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (branch_haz) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            halted <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            // write and clear indices never collide: writes land in free slots
            for (int j = 0; j < N_WAY; j++) begin
                if (CW'(j) < in_accept) begin
                    mem[PW'(tail + PW'(j))]       <= in_packet[j];
                    mem[PW'(tail + PW'(j))].valid <= 1'b1;
                end
            end
            for (int i = 0; i < N_WAY; i++) begin
                if (CW'(i) < deq)
                    mem[PW'(head + PW'(i))].valid <= 1'b0;
            end
            head  <= head + PW'(deq);
            tail  <= tail + PW'(in_accept);
            count <= count + OW'(in_accept) - OW'(deq);
            if (halt_take) halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dispatch_buffer.sv
// Bench for dispatch_buffer: a directed vector table plus a random wrap run,
// with a PC scoreboard queue tracking program order through the buffer.
module tb_dispatch_buffer;
    import dispatch_buffer_pkg::*;

    localparam int NW = 2;
    localparam int DP = 8;

    logic                    clock = 1'b0;
    logic                    reset;
    DISPATCH_PACKET [NW-1:0] in_packet;
    logic [1:0]              in_num, in_accept, dispatch_num;
    DISPATCH_PACKET [NW-1:0] dispatch_packet;
    logic [NW-1:0]           dispatched;
    logic                    branch_haz, halted;
    logic [3:0]              count;

    dispatch_buffer #(.N_WAY(NW), .DEPTH(DP)) dut (
        .clock(clock), .reset(reset), .in_packet(in_packet), .in_num(in_num),
        .in_accept(in_accept), .dispatch_packet(dispatch_packet),
        .dispatch_num(dispatch_num), .dispatched(dispatched),
        .branch_haz(branch_haz), .halted(halted), .count(count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         n;
        logic [1:0] hm;   // bit0: slot0 halt, bit1: slot1 illegal
        logic [1:0] d;
        logic       bh;
        int         acc;  // -1: no table check
        int         cnt;
    } vec_t;

    vec_t        tbl [21];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] sb [$];
    logic        m_halted;
    logic [31:0] next_pc;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle from the negedge, check combinational outputs, clock,
    // update the scoreboard and check registered state at the next negedge
    task automatic step(input int n, input logic [1:0] hm, input logic [1:0] d,
                        input logic bh, input int eacc, input int ecnt);
        int acc, lim, deq, nv;
        in_num = n[1:0];
        for (int j = 0; j < NW; j++) begin
            in_packet[j]         = '0;
            in_packet[j].valid   = (j < n);
            in_packet[j].pc      = next_pc + 32'(4 * j);
            in_packet[j].inst    = 32'h1300_0000 + 32'(j);
            in_packet[j].halt    = hm[j] && (j == 0);
            in_packet[j].illegal = hm[j] && (j == 1);
        end
        dispatched = d;
        branch_haz = bh;
        #1;
        nv  = (sb.size() < NW) ? sb.size() : NW;
        lim = (n < NW) ? n : NW;
        if (lim > DP - sb.size()) lim = DP - sb.size();
        acc = lim;
        for (int k = 0; k < lim; k++)
            if (hm[k]) begin acc = k + 1; break; end
        if (m_halted || bh) acc = 0;
        chk("in_accept", int'(in_accept), acc);
        if (eacc >= 0) chk("tbl_accept", int'(in_accept), eacc);
        chk("dispatch_num", int'(dispatch_num), nv);
        for (int i = 0; i < NW; i++) begin
            if (i < nv) chk("slot_pc", int'(dispatch_packet[i].pc), int'(sb[i]));
            else        chk("slot_unused_valid", int'(dispatch_packet[i].valid), 0);
        end
        deq = 0;
        for (int i = 0; i < nv; i++)
            if (d[i]) deq++; else break;
        @(posedge clock);
        if (bh) begin
            sb.delete();
            m_halted = 1'b0;
        end else begin
            repeat (deq) void'(sb.pop_front());
            for (int j = 0; j < acc; j++) sb.push_back(next_pc + 32'(4 * j));
            if (acc > 0 && hm[acc-1]) m_halted = 1'b1;
            next_pc = next_pc + 32'(4 * acc);
        end
        @(negedge clock);
        chk("count", int'(count), sb.size());
        chk("halted", int'(halted), int'(m_halted));
        if (ecnt >= 0) chk("tbl_count", int'(count), ecnt);
    endtask

    initial begin
        int r, start_pc;
        logic [1:0] rd;

        tbl[0]  = '{2, 2'b00, 2'b00, 1'b0, 2, 2};
        tbl[1]  = '{2, 2'b00, 2'b00, 1'b0, 2, 4};
        tbl[2]  = '{2, 2'b00, 2'b00, 1'b0, 2, 6};
        tbl[3]  = '{2, 2'b00, 2'b00, 1'b0, 2, 8};
        tbl[4]  = '{2, 2'b00, 2'b11, 1'b0, 0, 6};
        tbl[5]  = '{2, 2'b00, 2'b00, 1'b0, 2, 8};
        tbl[6]  = '{0, 2'b00, 2'b11, 1'b0, 0, 6};
        tbl[7]  = '{0, 2'b00, 2'b11, 1'b0, 0, 4};
        tbl[8]  = '{0, 2'b00, 2'b01, 1'b0, 0, 3};
        tbl[9]  = '{0, 2'b00, 2'b01, 1'b0, 0, 2};
        tbl[10] = '{0, 2'b00, 2'b10, 1'b0, 0, 2};
        tbl[11] = '{2, 2'b01, 2'b00, 1'b0, 1, 3};
        tbl[12] = '{2, 2'b00, 2'b00, 1'b0, 0, 3};
        tbl[13] = '{0, 2'b00, 2'b00, 1'b1, 0, 0};
        tbl[14] = '{2, 2'b10, 2'b00, 1'b0, 2, 2};
        tbl[15] = '{1, 2'b00, 2'b00, 1'b0, 0, 2};
        tbl[16] = '{0, 2'b00, 2'b00, 1'b1, 0, 0};
        tbl[17] = '{2, 2'b00, 2'b00, 1'b0, 2, 2};
        tbl[18] = '{2, 2'b00, 2'b00, 1'b0, 2, 4};
        tbl[19] = '{1, 2'b00, 2'b00, 1'b0, 1, 5};
        tbl[20] = '{2, 2'b00, 2'b11, 1'b1, 0, 0};

        reset      = 1'b1;
        in_num     = 2'd2;
        in_packet  = '0;
        dispatched = '0;
        branch_haz = 1'b0;
        m_halted   = 1'b0;
        next_pc    = 32'h0;
        #12;
        chk("rst_dispatch_num", int'(dispatch_num), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_in_accept", int'(in_accept), 2);
        chk("rst_slot0_valid", int'(dispatch_packet[0].valid), 0);
        @(negedge clock);
        reset = 1'b0;

        foreach (tbl[i])
            step(tbl[i].n, tbl[i].hm, tbl[i].d, tbl[i].bh, tbl[i].acc, tbl[i].cnt);

        // Random traffic long enough for head and tail to wrap past index 7
        start_pc = int'(next_pc);
        for (int it = 0; it < 300; it++) begin
            if ((int'(next_pc) - start_pc) / 4 >= 20 && sb.size() == 0) break;
            r  = $urandom_range(0, 3);
            rd = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r == 2) ? 2'b11 : 2'b10;
            if ((int'(next_pc) - start_pc) / 4 < 20)
                step($urandom_range(0, 2), 2'b00, rd, 1'b0, -1, -1);
            else
                step(0, 2'b00, rd, 1'b0, -1, -1);
        end
        chk("wrap_drained", sb.size(), 0);
        chk("wrap_issued_20", ((int'(next_pc) - start_pc) / 4 >= 20) ? 1 : 0, 1);

        // Asynchronous reset pulse in the middle of a cycle
        step(2, 2'b00, 2'b00, 1'b0, 2, 2);
        in_num     = 2'd0;
        dispatched = '0;
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_dispatch_num", int'(dispatch_num), 0);
        chk("midrst_count", int'(count), 0);
        sb.delete();
        m_halted = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        step(2, 2'b00, 2'b00, 1'b0, 2, 2);
        step(0, 2'b00, 2'b11, 1'b0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dispatch_buffer.md
Name: dispatch_buffer

Overview:
- In-order instruction queue between the decode stage and the ROB/map-table/free-list cluster (top_rob).
- Accepts up to N_WAY decoded DISPATCH_PACKETs per cycle and presents the oldest N_WAY entries to the rename/ROB cluster.
- Retires entries according to the per-slot dispatched mask returned by that cluster.
- Flushes on branch_haz and stops accepting after a halt/illegal instruction.

Parameters:
- N_WAY, 2, superscalar width (matches `N_WAY).
- DEPTH, 8, buffer entries; must be a power of two and >= 2*N_WAY.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_packet  in  N_WAY x DISPATCH_PACKET  decoded instructions; slot 0 is oldest.
- in_num  in  $clog2(N_WAY)+1  number of valid leading slots in in_packet (0..N_WAY).
- in_accept  out  $clog2(N_WAY)+1  number of in_packet slots the buffer accepts this cycle; upstream retires exactly this many.
- dispatch_packet  out  N_WAY x DISPATCH_PACKET  oldest entries; .valid=0 on unused slots.
- dispatch_num  out  $clog2(N_WAY)+1  number of valid slots in dispatch_packet.
- dispatched  in  N_WAY  per-slot acceptance from the ROB/free-list cluster.
- branch_haz  in  1  mispredict flush from the ROB.
- halted  out  1  a halt/illegal instruction has been enqueued; further enqueue is blocked.
- count  out  $clog2(DEPTH)+1  current occupancy (debug).

Behaviour:
- Storage: circular array of DEPTH entries with head and tail pointers of $clog2(DEPTH) bits (wrap modulo DEPTH) and a separate count register. Full = count==DEPTH. Empty = count==0.
- Reset (asynchronous): head=0, tail=0, count=0, halted=0, all entry .valid=0. Resulting outputs: dispatch_num=0, all dispatch_packet .valid=0, in_accept=min(in_num,N_WAY).
- Output path (combinational from registered state):
  - dispatch_packet[i] = entry[(head+i) mod DEPTH] for i < min(count,N_WAY); otherwise the slot is all-zero with valid=0.
  - dispatch_num = min(count,N_WAY).
- Dequeue:
  - deq = number of leading ones in (dispatched & slot valid).
  - A non-prefix mask (e.g. 2'b10) dequeues only the prefix, so 2'b10 gives deq=0.
  - head += deq; entries leaving the buffer have .valid cleared.
- Enqueue acceptance:
  - free = DEPTH - count, taken from registered count only. Slots freed by this cycle's dequeue are NOT reusable in the same cycle; this breaks any combinational loop through the ROB.
  - in_accept = 0 if halted or branch_haz; otherwise min(in_num, free, N_WAY).
  - Within the accepted prefix, if slot k is halt or illegal, the accept count is truncated to k+1. Only the halt itself is taken, and halted sets next cycle.
  - Accepted slots are written at (tail+j) mod DEPTH; tail += in_accept.
- Occupancy: count_next = count + in_accept - deq. Width is $clog2(DEPTH)+1 with no overflow, guaranteed by the free rule.
- Flush: on branch_haz=1 at a clock edge, next-cycle state is head=0, tail=0, count=0, halted=0. Dequeue and enqueue that cycle are discarded, and in_accept is forced to 0 in that cycle.
- Simultaneous full + dequeue: in_accept=0 that cycle; count drops by deq.
- Wrap-around: reads and writes crossing index DEPTH-1 to 0 must present packets in program order.
- Latency: an entry accepted at edge t is visible on dispatch_packet in cycle t+1, the earliest possible.
- Reset asserted mid-operation clears state immediately (asynchronous); outputs reflect the empty state before the next edge.

Decomposition:
- DISPATCH_PACKET, `N_WAY and a new DBUF_DEPTH constant live in the shared sys_defs package.
- One sub-module is natural: prefix_count (parameterised width), returning the count of leading ones of a vector. It is used for both deq and the halt/illegal truncation.
- The rest is a single always_ff for pointers and storage plus an always_comb for the outputs.

Test Plan:
1. Reset then in_num=2 with PCs 0x0/0x4 and dispatched=0 → in_accept=2; next cycle dispatch_num=2, PCs 0x0/0x4, count=2.
2. Fill to 8, in_num=2, dispatched=2'b11 → in_accept=0 that cycle; next cycle count=6; following cycle in_accept=2.
3. Partial dispatch: count=3, dispatched=2'b01 → next cycle count=2 and slot 0 holds the former slot 1. dispatched=2'b10 → count unchanged.
4. Wrap: cycle 20 instructions through with random dispatched prefixes → output PC sequence strictly +4 across the head wrap 7→0.
5. in_num=2 with slot 0 halt → in_accept=1, halted=1 next cycle, later in_num=2 gets in_accept=0. Then branch_haz=1 → count=0, halted=0, dispatch_num=0.
6. branch_haz=1 concurrent with in_num=2 and dispatched=2'b11 at count=5 → in_accept=0, next cycle count=0. Reset pulse mid-cycle → dispatch_num=0 immediately.
